// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32I opcodes and the decoder's control bundle for the
// ID/EX control stage. SLT support is enabled by defining ALU_CTRL_SLT_EN.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1110;
    localparam logic [3:0] ALU_SLT  = 4'b1101;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'b00,
        OP1_PC   = 2'b01,
        OP1_ZERO = 2'b10
    } op1_sel_t;

    typedef struct packed {
        logic [3:0]  alu_control;
        op1_sel_t    op1_sel;
        logic        op2_imm;
        logic [31:0] imm;
        logic        reg_write;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32I decoder: instruction word -> ALU control bundle.
// ALU_CTRL_SLT_EN enables SLT/SLTI/BLT/BGE; otherwise they decode as illegal.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        slt_ok, ill;

    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

`ifdef ALU_CTRL_SLT_EN
    assign slt_ok = 1'b1;
`else
    assign slt_ok = 1'b0;
`endif

    always_comb begin
        dec_o             = '0;
        dec_o.alu_control = ALU_ADD;
        dec_o.op1_sel     = OP1_RS1;
        ill               = 1'b0;
        case (opc)
            OPC_OP, OPC_OPIMM: begin
                dec_o.reg_write = 1'b1;
                dec_o.op2_imm   = (opc == OPC_OPIMM);
                dec_o.imm       = imm_i;
                case (f3)
                    3'b000: dec_o.alu_control = (opc == OPC_OP && f7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001: dec_o.alu_control = ALU_SLL;
                    3'b010: begin
                        dec_o.alu_control = ALU_SLT;
                        ill = !slt_ok;
                    end
                    3'b011: dec_o.alu_control = ALU_SLTU;
                    3'b100: dec_o.alu_control = ALU_XOR;
                    3'b101: dec_o.alu_control = f7[5] ? ALU_SRA : ALU_SRL;
                    3'b110: dec_o.alu_control = ALU_OR;
                    default: dec_o.alu_control = ALU_AND;
                endcase
                // funct7 is an opcode extension for R-type and for immediate shifts
                if (opc == OPC_OP || f3 == 3'b001 || f3 == 3'b101) begin
                    if (f7 != F7_BASE && f7 != F7_ALT)
                        ill = 1'b1;
                    if (f7 == F7_ALT && f3 != 3'b000 && f3 != 3'b101)
                        ill = 1'b1;
                end
                if (opc == OPC_OPIMM && f3[1:0] == 2'b01)
                    dec_o.imm = {27'b0, instr_i[24:20]};
            end
            OPC_LOAD: begin
                dec_o.reg_write = 1'b1;
                dec_o.op2_imm   = 1'b1;
                dec_o.imm       = imm_i;
                ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                dec_o.op2_imm = 1'b1;
                dec_o.imm     = imm_s;
                ill = f3[2] || (f3 == 3'b011);
            end
            OPC_BRANCH: begin
                dec_o.imm = imm_b;
                case (f3)
                    3'b000, 3'b001: dec_o.alu_control = ALU_SUB;
                    3'b100, 3'b101: begin
                        dec_o.alu_control = ALU_SLT;
                        ill = !slt_ok;
                    end
                    3'b110, 3'b111: dec_o.alu_control = ALU_SLTU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_JALR: begin
                dec_o.reg_write = 1'b1;
                dec_o.op2_imm   = 1'b1;
                dec_o.imm       = imm_i;
                ill = (f3 != 3'b000);
            end
            OPC_JAL: begin
                dec_o.reg_write = 1'b1;
                dec_o.op1_sel   = OP1_PC;
                dec_o.op2_imm   = 1'b1;
                dec_o.imm       = imm_j;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_o.reg_write = 1'b1;
                dec_o.op1_sel   = (opc == OPC_LUI) ? OP1_ZERO : OP1_PC;
                dec_o.op2_imm   = 1'b1;
                dec_o.imm       = imm_u;
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            dec_o             = '0;
            dec_o.alu_control = ALU_ADD;
            dec_o.illegal     = 1'b1;
        end
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX control register: decodes the ID instruction, applies flush/stall and
// counts illegal instructions. ALU_CTRL_SLT_EN is honoured by alu_ctrl_dec.
module alu_ctrl_stage
    import alu_pkg::*;
#(
    parameter int REG_WIDTH = 32,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 id_valid,
    input  logic [31:0]          id_instr,
    input  logic [REG_WIDTH-1:0] id_pc,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 ex_valid,
    output logic [3:0]           ex_alu_control,
    output logic [1:0]           ex_op1_sel,
    output logic                 ex_op2_imm,
    output logic [REG_WIDTH-1:0] ex_imm,
    output logic [REG_WIDTH-1:0] ex_pc,
    output logic [4:0]           ex_rs1,
    output logic [4:0]           ex_rs2,
    output logic [4:0]           ex_rd,
    output logic                 ex_reg_write,
    output logic                 ex_illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    typedef struct packed {
        logic                 valid;
        logic [3:0]           alu;
        logic [1:0]           op1;
        logic                 op2_imm;
        logic [REG_WIDTH-1:0] imm;
        logic [REG_WIDTH-1:0] pc;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        logic                 reg_write;
        logic                 illegal;
    } ex_t;

    dec_t                 dec;
    ex_t                  ex_q, ex_d;
    logic [ILL_CNT_W-1:0] cnt_q, cnt_d;

    alu_ctrl_dec u_dec (
        .instr_i (id_instr),
        .dec_o   (dec)
    );

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        // flush and an empty ID slot both produce a fully cleared bubble
        if (flush || (!stall && !id_valid)) begin
            ex_d     = '0;
            ex_d.alu = ALU_ADD;
        end else if (!stall) begin
            ex_d.valid     = 1'b1;
            ex_d.alu       = dec.alu_control;
            ex_d.op1       = dec.op1_sel;
            ex_d.op2_imm   = dec.op2_imm;
            ex_d.imm       = REG_WIDTH'(signed'(dec.imm));
            ex_d.pc        = id_pc;
            ex_d.rs1       = id_instr[19:15];
            ex_d.rs2       = id_instr[24:20];
            ex_d.rd        = id_instr[11:7];
            ex_d.reg_write = dec.reg_write;
            ex_d.illegal   = dec.illegal;
            if (dec.illegal && cnt_q != '1)
                cnt_d = cnt_q + ILL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ex_q     <= '0;
            ex_q.alu <= ALU_ADD;
            cnt_q    <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid       = ex_q.valid;
    assign ex_alu_control = ex_q.alu;
    assign ex_op1_sel     = ex_q.op1;
    assign ex_op2_imm     = ex_q.op2_imm;
    assign ex_imm         = ex_q.imm;
    assign ex_pc          = ex_q.pc;
    assign ex_rs1         = ex_q.rs1;
    assign ex_rs2         = ex_q.rs2;
    assign ex_rd          = ex_q.rd;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_illegal     = ex_q.illegal;
    assign ill_count      = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage: mnemonic-level reference model plus
// directed vectors with literal expectations. Honours ALU_CTRL_SLT_EN.
module tb_alu_ctrl_stage;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = '0;
    logic [31:0] id_pc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid;
    logic [3:0]  ex_alu_control;
    logic [1:0]  ex_op1_sel;
    logic        ex_op2_imm;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_reg_write;
    logic        ex_illegal;
    logic [7:0]  ill_count;

    int checks = 0;
    int errors = 0;

    alu_ctrl_stage #(.REG_WIDTH(32), .ILL_CNT_W(8)) dut (
        .clk(clk), .reset_b(reset_b), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_alu_control(ex_alu_control), .ex_op1_sel(ex_op1_sel), .ex_op2_imm(ex_op2_imm),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal), .ill_count(ill_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (mnemonic level) ----------------
    string R0  [8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
    string IMM [8] = '{"ADDI", "", "SLTI", "SLTIU", "XORI", "", "ORI", "ANDI"};
    string LD  [8] = '{"LB", "LH", "LW", "", "LBU", "LHU", "", ""};
    string BR  [8] = '{"BEQ", "BNE", "", "", "BLT", "BGE", "BLTU", "BGEU"};

    function automatic string mnem(input logic [31:0] w);
        logic [6:0] f7;
        logic [2:0] f3;
        string s;
        f7 = w[31:25];
        f3 = w[14:12];
        s  = "";
        case (w[6:0])
            7'b0110011: begin
                if (f7 == 7'h00) s = R0[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) s = "SUB";
                else if (f7 == 7'h20 && f3 == 3'd5) s = "SRA";
            end
            7'b0010011: begin
                if (f3 == 3'd1) s = (f7 == 7'h00) ? "SLLI" : "";
                else if (f3 == 3'd5) s = (f7 == 7'h00) ? "SRLI" : (f7 == 7'h20) ? "SRAI" : "";
                else s = IMM[f3];
            end
            7'b0000011: s = LD[f3];
            7'b0100011: s = (f3 == 3'd0) ? "SB" : (f3 == 3'd1) ? "SH" : (f3 == 3'd2) ? "SW" : "";
            7'b1100011: s = BR[f3];
            7'b1100111: s = (f3 == 3'd0) ? "JALR" : "";
            7'b1101111: s = "JAL";
            7'b0110111: s = "LUI";
            7'b0010111: s = "AUIPC";
            default:    s = "";
        endcase
`ifndef ALU_CTRL_SLT_EN
        if (s == "SLT" || s == "SLTI" || s == "BLT" || s == "BGE") s = "";
`endif
        if (s == "") s = "ILL";
        return s;
    endfunction

    function automatic logic [3:0] alu_of(input string m);
        if (m == "SUB" || m == "BEQ" || m == "BNE") return 4'b0110;
        if (m == "AND" || m == "ANDI") return 4'b0000;
        if (m == "OR" || m == "ORI") return 4'b0001;
        if (m == "XOR" || m == "XORI") return 4'b0011;
        if (m == "SLL" || m == "SLLI") return 4'b0111;
        if (m == "SRL" || m == "SRLI") return 4'b1001;
        if (m == "SRA" || m == "SRAI") return 4'b1011;
        if (m == "SLTU" || m == "SLTIU" || m == "BLTU" || m == "BGEU") return 4'b1110;
        if (m == "SLT" || m == "SLTI" || m == "BLT" || m == "BGE") return 4'b1101;
        return 4'b0010;
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] w, input string m);
        if (m == "SLLI" || m == "SRLI" || m == "SRAI") return {27'b0, w[24:20]};
        case (w[6:0])
            7'b0100011: return 32'($signed({w[31:25], w[11:7]}));
            7'b1100011: return 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            7'b0110111, 7'b0010111: return {w[31:12], 12'h000};
            7'b1101111: return 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            default: return 32'($signed(w) >>> 20);
        endcase
    endfunction

    logic       m_valid, m_rw, m_ill, m_op2, m_immchk;
    logic [3:0] m_alu;
    logic [1:0] m_op1;
    logic [31:0] m_imm, m_pc;
    logic [4:0] m_rs1, m_rs2, m_rd;
    int         m_cnt;

    always @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            m_valid <= 1'b0; m_rw <= 1'b0; m_ill <= 1'b0; m_cnt <= 0;
        end else if (flush) begin
            m_valid <= 1'b0; m_rw <= 1'b0; m_ill <= 1'b0;
        end else if (!stall) begin
            m_valid  <= id_valid;
            m_ill    <= id_valid && mnem(id_instr) == "ILL";
            m_rw     <= id_valid && mnem(id_instr) != "ILL" &&
                        id_instr[6:0] != 7'b0100011 && id_instr[6:0] != 7'b1100011;
            m_alu    <= alu_of(mnem(id_instr));
            m_op1    <= (mnem(id_instr) == "LUI") ? 2'b10 :
                        (mnem(id_instr) == "AUIPC" || mnem(id_instr) == "JAL") ? 2'b01 : 2'b00;
            m_op2    <= !(id_instr[6:0] == 7'b0110011 || id_instr[6:0] == 7'b1100011);
            m_immchk <= id_instr[6:0] != 7'b0110011;
            m_imm    <= imm_of(id_instr, mnem(id_instr));
            m_pc     <= id_pc;
            m_rs1    <= id_instr[19:15];
            m_rs2    <= id_instr[24:20];
            m_rd     <= id_instr[11:7];
            if (id_valid && mnem(id_instr) == "ILL" && m_cnt < 255) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        chk("valid", ex_valid, m_valid);
        chk("reg_write", ex_reg_write, m_rw);
        chk("illegal", ex_illegal, m_ill);
        chk("ill_count", ill_count, m_cnt);
        if (m_valid) begin
            chk("alu_control", ex_alu_control, m_alu);
            chk("pc", ex_pc, m_pc);
            chk("rs1", ex_rs1, m_rs1);
            chk("rs2", ex_rs2, m_rs2);
            chk("rd", ex_rd, m_rd);
        end
        if (m_valid && !m_ill) begin
            chk("op1_sel", ex_op1_sel, m_op1);
            chk("op2_imm", ex_op2_imm, m_op2);
            if (m_immchk) chk("imm", ex_imm, m_imm);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic v, input logic [31:0] ins, input logic s, input logic f);
        id_valid = v; id_instr = ins; stall = s; flush = f; id_pc = id_pc + 32'd4;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] vec [16] = '{
        32'h402081B3, 32'h40735293, 32'h0020E463, 32'h003120B3,
        32'h123450B7, 32'hFFF00093, 32'h00001117, 32'h008000EF,
        32'hFFC12283, 32'h00512423, 32'h00008067, 32'h0020C463,
        32'h022081B3, 32'h0F017093, 32'h403110B3, 32'hFFF13093
    };

    initial begin
        id_pc = 32'h0000_1000;
        // reset with random inputs
        repeat (3) begin
            id_valid = 1'($urandom); id_instr = $urandom; stall = 1'($urandom); flush = 1'($urandom);
            @(posedge clk);
            #1;
        end
        chk("rst ex_valid", ex_valid, 1'b0);
        chk("rst alu", ex_alu_control, 4'b0010);
        chk("rst op1", ex_op1_sel, 2'b00);
        chk("rst ill_count", ill_count, 8'd0);
        chk("rst imm", ex_imm, 32'd0);
        reset_b = 1'b1;

        drive(1'b1, 32'h402081B3, 1'b0, 1'b0);   // SUB x3,x1,x2
        chk("sub alu", ex_alu_control, 4'b0110);
        chk("sub rs1", ex_rs1, 5'd1);
        chk("sub rs2", ex_rs2, 5'd2);
        chk("sub rd", ex_rd, 5'd3);
        chk("sub op2_imm", ex_op2_imm, 1'b0);
        chk("sub reg_write", ex_reg_write, 1'b1);

        drive(1'b1, 32'h40735293, 1'b0, 1'b0);   // SRAI x5,x6,7
        chk("srai alu", ex_alu_control, 4'b1011);
        chk("srai imm", ex_imm, 32'd7);
        chk("srai op2_imm", ex_op2_imm, 1'b1);

        drive(1'b1, 32'h0020E463, 1'b0, 1'b0);   // BLTU x1,x2,+8
        for (int i = 0; i < 4; i++) begin
            chk("bltu alu", ex_alu_control, 4'b1110);
            chk("bltu reg_write", ex_reg_write, 1'b0);
            chk("bltu valid", ex_valid, 1'b1);
            if (i < 3) drive(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        end
        drive(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);   // stall+flush
        chk("stall+flush valid", ex_valid, 1'b0);
        chk("stall+flush count", ill_count, 8'd0);

        drive(1'b1, 32'h003120B3, 1'b0, 1'b0);   // SLT x1,x2,x3
`ifdef ALU_CTRL_SLT_EN
        chk("slt alu", ex_alu_control, 4'b1101);
        chk("slt illegal", ex_illegal, 1'b0);
`else
        chk("slt illegal", ex_illegal, 1'b1);
        chk("slt reg_write", ex_reg_write, 1'b0);
        chk("slt ill_count", ill_count, 8'd1);
        chk("slt alu", ex_alu_control, 4'b0010);
`endif

        drive(1'b1, 32'h123450B7, 1'b0, 1'b0);   // LUI x1,0x12345
        chk("lui imm", ex_imm, 32'h12345000);
        chk("lui op1", ex_op1_sel, 2'b10);
        drive(1'b1, 32'hFFF00093, 1'b0, 1'b0);   // ADDI x1,x0,-1
        chk("addi imm", ex_imm, 32'hFFFFFFFF);
        drive(1'b1, 32'h00512423, 1'b0, 1'b0);   // SW x5,8(x2)
        chk("sw imm", ex_imm, 32'd8);
        chk("sw reg_write", ex_reg_write, 1'b0);

        // table sweep: clean pass, then with stall/flush/bubble interleaving
        for (int i = 0; i < 16; i++) drive(1'b1, vec[i], 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            drive(i % 4 != 3, vec[i], i % 3 == 1, i % 5 == 4);

        for (int i = 0; i < 300; i++) drive(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("sat count", ill_count, 8'd255);
        drive(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
        chk("sat flush count", ill_count, 8'd255);
        chk("sat flush valid", ex_valid, 1'b0);

        // asynchronous reset in the middle of a stall
        drive(1'b1, 32'h402081B3, 1'b0, 1'b0);
        stall = 1'b1;
        #2 reset_b = 1'b0;
        #1;
        chk("async rst valid", ex_valid, 1'b0);
        chk("async rst alu", ex_alu_control, 4'b0010);
        chk("async rst count", ill_count, 8'd0);
        #2 reset_b = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 32'h003140B3, 1'b0, 1'b0);   // XOR x1,x2,x3
        chk("post-rst xor alu", ex_alu_control, 4'b0011);
        chk("post-rst valid", ex_valid, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Decode-to-execute control stage for the RV32I pipeline. It decodes the ID-stage instruction into the 4-bit `alu_control` code, operand selects and immediate consumed by the EX-stage ALU, and registers them into the ID/EX pipeline register. It handles pipeline stall and flush and keeps a saturating count of illegal instructions. It is the producer end of the ALU control interface.

## Interface
- `REG_WIDTH`, 32, datapath/immediate width
- `ILL_CNT_W`, 8, illegal-instruction counter width

- `clk`  in  1  clock, rising edge
- `reset_b`  in  1  reset, asynchronous, active-low
- `id_valid`  in  1  ID holds a valid instruction
- `id_instr`  in  32  instruction word
- `id_pc`  in  REG_WIDTH  instruction PC
- `stall`  in  1  hold the ID/EX register
- `flush`  in  1  insert a bubble into EX
- `ex_valid`  out  1  EX slot holds an instruction
- `ex_alu_control`  out  4  ALU op code
- `ex_op1_sel`  out  2  ALU operand 1 select: 00 = rs1, 01 = PC, 10 = zero
- `ex_op2_imm`  out  1  1 = operand 2 is `ex_imm`, 0 = rs2
- `ex_imm`  out  REG_WIDTH  sign-extended immediate
- `ex_pc`  out  REG_WIDTH  registered PC
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5 each  register indices
- `ex_reg_write`  out  1  write back `rd`
- `ex_illegal`  out  1  instruction failed to decode
- `ill_count`  out  ILL_CNT_W  saturating illegal-instruction count

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLL 0111, SRL 1001, SRA 1011, SLTU 1110, SLT 1101 (SLT exists only with the macro below).
- R-type (0110011) and I-ALU (0010011) map funct3/funct7[5] to these codes.
  - SUB only for R-type with funct7 = 0100000.
  - SRAI/SRA when funct7[5] = 1.
  - Shift immediates: `ex_imm` = zero-extended shamt.
  - funct7 other than 0000000/0100000 is illegal.
- Load, store and JALR: ADD, `op2_imm` = 1. Stores and branches drive `reg_write` = 0.
- LUI: ADD, op1 = zero, imm = U-imm.
- AUIPC: ADD, op1 = PC.
- JAL: ADD, op1 = PC, imm = J-imm.
- Branches:
  - BEQ/BNE use SUB.
  - BLTU/BGEU use SLTU.
  - BLT/BGE use SLT with the macro and are illegal without it.
- Illegal or unknown opcode: `ex_illegal` = 1, `reg_write` = 0, ADD, `ex_valid` still follows `id_valid`.

## Timing
- Latency 1 cycle: ID inputs sampled at edge N appear on `ex_*` after edge N.
- Reset values: every output 0, except `ex_alu_control` = 0010 (ADD) and `ex_op1_sel` = 00.
- Priority per edge: flush > stall > load.
  - flush: `ex_valid` ← 0, `ex_reg_write` ← 0, `ex_illegal` ← 0; other fields are don't-care but are cleared.
  - stall without flush: all `ex_*` hold.
  - Otherwise `ex_*` load from the decode of the ID inputs. `id_valid` = 0 loads a bubble.
- `ill_count` increments on each edge where an illegal valid instruction loads (no stall, no flush). It saturates at all-ones. It is not cleared by flush.
- Reset asserted mid-stall or mid-flush: outputs go to reset values asynchronously. The first edge after release loads normally.

## Configuration
- `ALU_CTRL_SLT_EN` defined:
  - SLT/SLTI decode to 1101.
  - BLT/BGE decode to 1101, and EX tests the LSB.
- `ALU_CTRL_SLT_EN` undefined:
  - SLT, SLTI, BLT and BGE are illegal.
  - The 1101 code is never emitted.

## Structure
- Package `alu_pkg`:
  - ALU op localparams (the codes above).
  - Opcode constants.
  - `op1_sel_t` enum.
- Sub-module `alu_ctrl_dec`: purely combinational decoder, instruction → control bundle.
- `alu_ctrl_stage` holds the ID/EX register, the flush/stall logic and the counter.

## Test plan
- Reset: drive `reset_b` = 0 with random inputs → `ex_valid` = 0, `ex_alu_control` = 0010, `ill_count` = 0.
- SUB x3,x1,x2 (0x402081B3), valid → next cycle `alu_control` = 0110, rs1 = 1, rs2 = 2, rd = 3, `op2_imm` = 0, `reg_write` = 1.
- SRAI x5,x6,7 (0x40735293) → `alu_control` = 1011, `ex_imm` = 7, `op2_imm` = 1.
- BLTU, then stall held for 3 cycles → `alu_control` = 1110 and `reg_write` = 0, constant for all 3 cycles. Stall + flush together → `ex_valid` = 0 next cycle.
- SLT x1,x2,x3 (0x003120B3):
  - with the macro → 1101, `ex_illegal` = 0.
  - without it → `ex_illegal` = 1, `reg_write` = 0, `ill_count` = 1.
- Send 300 illegal words (0xFFFFFFFF) → `ill_count` saturates at 255. Flush on the 301st → count stays 255.
